hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_pkg.sv | 29 ++
 rtl/hilo_div.sv | 135 +++++++++++++
 rtl/hilo_unit.sv | 98 +++++++++
 tb/tb_hilo_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encoding and divider state.
package hilo_pkg;

  localparam logic [2:0] OPC_NOP   = 3'd0;
  localparam logic [2:0] OPC_MTHI  = 3'd1;
  localparam logic [2:0] OPC_MTLO  = 3'd2;
  localparam logic [2:0] OPC_MULT  = 3'd3;
  localparam logic [2:0] OPC_MULTU = 3'd4;
  localparam logic [2:0] OPC_DIV   = 3'd5;
  localparam logic [2:0] OPC_DIVU  = 3'd6;
  localparam logic [2:0] OPC_MADD  = 3'd7;

  typedef enum logic [2:0] {
    OP_NOP   = OPC_NOP,
    OP_MTHI  = OPC_MTHI,
    OP_MTLO  = OPC_MTLO,
    OP_MULT  = OPC_MULT,
    OP_MULTU = OPC_MULTU,
    OP_DIV   = OPC_DIV,
    OP_DIVU  = OPC_DIVU,
    OP_MADD  = OPC_MADD
  } op_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/hilo_div.sv
// Iterative restoring divider: one quotient bit per falling edge, magnitudes in,
// sign fix-up applied combinationally on the final step so the result lands that edge.
//
// state    | meaning
// DIV_IDLE | waiting for start; operands are latched on the start edge
// DIV_RUN  | one restoring step per edge; leaves on the last step or on cancel
module hilo_div
  import hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic         wr,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic          done_q, done_d;

  logic [W:0]    rem_sh, diff;
  logic [W-1:0]  acc_step, quo_step, a_abs, b_abs;
  logic          last;

  always_comb begin
    a_abs  = (is_signed && a[W-1]) ? (~a + W'(1)) : a;
    b_abs  = (is_signed && b[W-1]) ? (~b + W'(1)) : b;
    rem_sh = {acc_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (diff[W]) begin
      acc_step = rem_sh[W-1:0];
      quo_step = {quo_q[W-2:0], 1'b0};
    end else begin
      acc_step = diff[W-1:0];
      quo_step = {quo_q[W-2:0], 1'b1};
    end
    last = (state_q == DIV_RUN) && (cnt_q == CNT_LAST) && !cancel;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = last;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_RUN;
          cnt_d   = CNT_LOAD;
          acc_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          dvd_d   = a;
          negq_d  = is_signed & (a[W-1] ^ b[W-1]);
          negr_d  = is_signed & a[W-1];
        end
      end
      DIV_RUN: begin
        if (cancel) begin
          state_d = DIV_IDLE;
        end else begin
          acc_d = acc_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // A zero divisor bypasses the fix-up: quotient all ones, remainder is the raw dividend.
  always_comb begin
    if (dvs_q == '0) begin
      quo = '1;
      rem = dvd_q;
    end else begin
      quo = negq_q ? (~quo_step + W'(1)) : quo_step;
      rem = negr_q ? (~acc_step + W'(1)) : acc_step;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == DIV_RUN);
  assign done = done_q;
  assign wr   = last;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with single-edge multiply / multiply-accumulate and an
// iterative divider; all state moves on the falling edge of clk.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           accept;
  logic           div_start, div_signed, div_wr, div_busy, div_done;
  logic [W-1:0]   div_quo, div_rem;
  logic [2*W-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*W-1:0] prod_s, prod_u, madd_sum;
  op_e            op_w;

  assign op_w = op_e'(op);

  // Operands widened up front so both products are exact modulo 2^(2W).
  assign a_sx     = {{W{a[W-1]}}, a};
  assign b_sx     = {{W{b[W-1]}}, b};
  assign a_zx     = {{W{1'b0}}, a};
  assign b_zx     = {{W{1'b0}}, b};
  assign prod_s   = a_sx * b_sx;
  assign prod_u   = a_zx * b_zx;
  assign madd_sum = {hi_q, lo_q} + prod_s;

  assign accept = valid && !div_busy;

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_start  = 1'b0;
    div_signed = 1'b0;
    if (div_wr) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end else if (accept) begin
      case (op_w)
        OP_MTHI:  hi_d = a;
        OP_MTLO:  lo_d = a;
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MADD:  {hi_d, lo_d} = madd_sum;
        OP_DIV: begin
          div_start  = 1'b1;
          div_signed = 1'b1;
        end
        OP_DIVU:  div_start = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  hilo_div #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (div_busy),
    .done      (div_done),
    .wr        (div_wr),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  assign busy = div_busy;
  assign done = div_done;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: arithmetic reference model compared every rising edge,
// plus literal expectations for the key vectors; a W=16 instance covers narrow divides.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        valid16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [15:0] hi16, lo16;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int n;

  always #5 clk = ~clk;

  hilo_unit #(.W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  hilo_unit #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .valid(valid16), .op(op16), .a(a16), .b(b16),
    .cancel(1'b0), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic and SV integer division semantics.
  logic [31:0] m_hi = '0, m_lo = '0, m_q = '0, m_r = '0;
  bit          m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;

  task automatic model_req(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      ps;
    logic [63:0] pu;
    int          sx, sy;
    ps = longint'($signed(x)) * longint'($signed(y));
    pu = {32'b0, x} * {32'b0, y};
    sx = x;
    sy = y;
    case (o)
      OPC_MTHI:  m_hi = x;
      OPC_MTLO:  m_lo = x;
      OPC_MULT:  {m_hi, m_lo} = ps;
      OPC_MULTU: {m_hi, m_lo} = pu;
      OPC_MADD:  {m_hi, m_lo} = {m_hi, m_lo} + 64'(ps);
      OPC_DIV, OPC_DIVU: begin
        if (y == 0) begin
          m_q = '1;
          m_r = x;
        end else if (o == OPC_DIVU) begin
          m_q = x / y;
          m_r = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_q = x;
          m_r = '0;
        end else begin
          m_q = sx / sy;
          m_r = sx % sy;
        end
        m_busy = 1'b1;
        m_left = 32;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (cancel) m_busy = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = m_r; m_lo = m_q; m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end else if (valid) begin
        model_req(op, a, b);
      end
    end
  end

  always @(posedge clk) begin
    if (cmp_en && rst) begin
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
    end
  end

  task automatic req(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; valid = 1'b1;
    @(posedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    req(OPC_MTHI, 32'h1234_5678, 0);
    req(OPC_MTLO, 32'h9ABC_DEF0, 0);
    check("mthi", hi, 32'h1234_5678);
    check("mtlo", lo, 32'h9ABC_DEF0);

    req(OPC_MULT, 32'hFFFF_FFFE, 3);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    req(OPC_MULTU, 32'hFFFF_FFFE, 3);
    check("multu_hi", hi, 32'h2);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    // 0x2_FFFFFFFA + 6 carries into HI.
    req(OPC_MADD, 2, 3);
    check("madd_hi", hi, 32'h3);
    check("madd_lo", lo, 32'h0);
    req(OPC_MADD, 32'hFFFF_FFFF, 5);
    check("madd_neg_hi", hi, 32'h2);
    check("madd_neg_lo", lo, 32'hFFFF_FFFB);

    cancel = 1'b1;
    @(posedge clk);
    cancel = 1'b0;
    check("idle_cancel_busy", busy, 0);
    check("idle_cancel_hi", hi, 32'h2);

    req(OPC_DIV, 32'hFFFF_FFF9, 2);
    check("div_busy", busy, 1);
    req(OPC_MULT, 5, 5);
    check("div_hold_lo", lo, 32'hFFFF_FFFB);
    n = 1;
    while (busy && n < 100) begin
      if (n == 31) begin
        op = OPC_MTHI; a = 32'hDEAD_BEEF; valid = 1'b1;
      end
      @(posedge clk);
      valid = 1'b0;
      n++;
    end
    check("div_latency", n, 32);
    check("div_done", done, 1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    @(posedge clk);
    check("div_done_clear", done, 0);

    req(OPC_DIVU, 100, 0);
    wait_idle(n);
    check("divz_latency", n, 32);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 100);
    req(OPC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 0);
    req(OPC_DIV, 7, 32'hFFFF_FFFE);
    wait_idle(n);
    check("div_7_m2_lo", lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", hi, 1);
    req(OPC_DIVU, 32'hFFFF_FFFF, 10);
    wait_idle(n);
    check("divu_big_lo", lo, 32'h1999_9999);
    check("divu_big_hi", hi, 5);

    req(OPC_DIVU, 100, 7);
    repeat (9) @(posedge clk);
    cancel = 1'b1;
    @(posedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    check("cancel_hi", hi, 5);
    check("cancel_lo", lo, 32'h1999_9999);
    repeat (3) @(posedge clk);
    req(OPC_DIVU, 100, 7);
    wait_idle(n);
    check("divu_100_7_lo", lo, 14);
    check("divu_100_7_hi", hi, 2);

    req(OPC_DIVU, 50, 3);
    repeat (31) @(posedge clk);
    cancel = 1'b1;
    @(posedge clk);
    cancel = 1'b0;
    check("late_cancel_busy", busy, 0);
    check("late_cancel_done", done, 0);
    check("late_cancel_lo", lo, 14);
    check("late_cancel_hi", hi, 2);

    req(OPC_DIV, 1000, 3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("amid_rst_hi", hi, 0);
    check("amid_rst_lo", lo, 0);
    check("amid_rst_busy", busy, 0);
    check("amid_rst_done", done, 0);
    @(posedge clk);
    rst = 1'b1;
    req(OPC_MTLO, 5, 0);
    check("post_rst_accept", lo, 5);

    op16 = OPC_DIVU; a16 = 16'd100; b16 = 16'd0; valid16 = 1'b1;
    @(posedge clk);
    valid16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("w16_divz_latency", n, 16);
    check("w16_divz_lo", lo16, 16'hFFFF);
    check("w16_divz_hi", hi16, 16'd100);
    op16 = OPC_DIV; a16 = 16'h8000; b16 = 16'hFFFF; valid16 = 1'b1;
    @(posedge clk);
    valid16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("w16_divovf_latency", n, 16);
    check("w16_divovf_lo", lo16, 16'h8000);
    check("w16_divovf_hi", hi16, 16'h0000);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
